// File: rtl/sum_result_buffer.sv
// sum_result_buffer
//   Captures sums from the operand-adder stage into a small in-order FIFO and
//   re-issues them downstream over a valid/ready handshake. It also keeps a
//   running total of accepted sums, a sticky accumulator-wrap flag and a
//   sticky drop flag. The adder cannot be stalled, so a sum that arrives while
//   the FIFO is full with no pop is lost and flagged.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   adder valid pulse
//   in_data    adder sum, W bits
//   out_valid  head entry available
//   out_ready  downstream accepts head entry
//   out_data   head entry, 0 when empty
//   count      occupied entries
//   acc        running sum of accepted inputs, modulo 2^ACC_W
//   acc_ovf    sticky, accumulator wrapped
//   drop_err   sticky, an input was lost on a full FIFO
//   clr_stats  synchronous clear of acc, acc_ovf, drop_err
module sum_result_buffer #(
    parameter int W     = 20,
    parameter int DEPTH = 4,
    parameter int ACC_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [W-1:0]               in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [ACC_W-1:0]           acc,
    output logic                       acc_ovf,
    output logic                       drop_err,
    input  logic                       clr_stats
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [ACC_W-1:0] r_acc;
    logic             r_acc_ovf;
    logic             r_drop_err;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [ACC_W-1:0] w_acc_base;
    logic [ACC_W:0]   w_in_ext;
    logic [ACC_W:0]   w_sum;
    logic             w_ovf_base;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = !w_empty && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push  = in_valid && (!w_full || w_pop);
    assign w_drop  = in_valid && !w_push;

    // Clear takes effect before the add so clr_stats+push leaves acc = in_data.
    assign w_acc_base = clr_stats ? '0 : r_acc;
    assign w_ovf_base = clr_stats ? 1'b0 : r_acc_ovf;
    assign w_in_ext   = {{(ACC_W+1-W){1'b0}}, in_data};
    assign w_sum      = {1'b0, w_acc_base} + w_in_ext;

    // Storage is not reset; out_data is gated by occupancy instead.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc      <= '0;
            r_acc_ovf  <= 1'b0;
            r_drop_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_acc     <= w_sum[ACC_W-1:0];
                r_acc_ovf <= w_ovf_base | w_sum[ACC_W];
            end else begin
                r_acc     <= w_acc_base;
                r_acc_ovf <= w_ovf_base;
            end
            r_drop_err <= w_drop | (clr_stats ? 1'b0 : r_drop_err);
        end
    end

    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign count     = r_count;
    assign acc       = r_acc;
    assign acc_ovf   = r_acc_ovf;
    assign drop_err  = r_drop_err;

endmodule

// File: doc/sum_result_buffer.md
Name: sum_result_buffer

Overview:
- Downstream consumer of the operand-adder stage. Captures each sum presented on the adder's y/valid outputs into a small in-order FIFO.
- Re-issues the captured sums to the next stage over a valid/ready handshake.
- Keeps a running total of accepted sums, plus sticky error and overflow flags.
- The adder has no backpressure, so this block absorbs bursts and flags any loss.

Parameters:
- W, 20, data width of each sum; matches the adder's W.
- DEPTH, 4, number of FIFO entries; must be a power of two and at least 2.
- ACC_W, 32, width of the running accumulator; must be at least W.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset; clears all state.
- in_valid  input  1  connects to the adder's valid; a 1-cycle pulse per sum.
- in_data  input  W  connects to the adder's y; sampled only when in_valid=1.
- out_valid  output  1  head entry is available on out_data.
- out_ready  input  1  downstream accepts the head entry this cycle.
- out_data  output  W  head entry; equals 0 when empty.
- count  output  $clog2(DEPTH+1)  current number of occupied entries.
- acc  output  ACC_W  sum of all accepted in_data values, modulo 2^ACC_W.
- acc_ovf  output  1  sticky; set when the accumulator wraps.
- drop_err  output  1  sticky; set when an input sum is lost because the FIFO is full.
- clr_stats  input  1  synchronous clear of acc, acc_ovf and drop_err.

Behaviour:
- Reset (rst=1, asynchronous):
  - FIFO empties; read and write pointers = 0.
  - count=0, out_valid=0, out_data=0, acc=0, acc_ovf=0, drop_err=0.
  - Any entries held at reset are discarded.
  - Deassertion of rst is synchronised by the system; the block takes no action on it.
- Push: in_valid=1, and either count<DEPTH or a pop occurs in the same cycle.
  - in_data is written at the write pointer, which then increments and wraps modulo DEPTH.
- Pop: out_valid=1 and out_ready=1.
  - Read pointer increments and wraps modulo DEPTH.
- Flow-through latency: a push into an empty FIFO makes out_valid=1 on the next cycle. There is no same-cycle bypass.
- count update: +1 on push only, -1 on pop only, unchanged on push+pop or on neither.
- Full (count=DEPTH) with push+pop in the same cycle: both are accepted, count stays at DEPTH, no drop.
- Full with in_valid=1 and no pop:
  - The entry is discarded; FIFO contents are unchanged.
  - drop_err is set on the next edge.
  - acc is NOT updated by a dropped value.
- Empty (count=0): out_valid=0 and out_data=0; out_ready is ignored.
- out_valid/out_data source:
  - Driven combinationally from registered state: out_valid = (count!=0), out_data = the entry at the read pointer.
  - Stable while out_valid=1 and out_ready=0.
- Accumulator:
  - On each accepted push, acc <= acc + zero-extended in_data, computed at ACC_W+1 bits.
  - If the carry-out is 1, acc_ovf is set (sticky) and acc keeps the low ACC_W bits.
- clr_stats=1:
  - acc, acc_ovf and drop_err are cleared on the next edge.
  - If a push is accepted in the same cycle, acc <= in_data (clear first, then add) and acc_ovf=0.
  - If a drop occurs in the same cycle, drop_err=1 (the set wins).
  - FIFO contents and count are unaffected.
- Unknown or X inputs are not required to be tolerated. Assertions are bound in the bench.

Test Plan:
- Reset check: hold rst=1 for 3 cycles, then release -> count=0, out_valid=0, out_data=0, acc=0, flags=0. Assert rst mid-stream with count=3 -> all outputs return to 0 immediately, without waiting for a clock edge.
- Single pass: push 0x00123 with out_ready=1 -> out_valid=1 with out_data=0x00123 exactly 1 cycle later, popped that same cycle. count goes 0->1->0; acc=0x123.
- Fill and drop: out_ready=0, push 5, 7, 9, 11, then 13 -> count=4. The value 13 is dropped, drop_err=1, acc=32. Then drain with out_ready=1 -> outputs 5, 7, 9, 11 in order, then out_valid=0.
- Full with simultaneous push and pop: count=4, in_valid=1 with in_data=20, out_ready=1 -> head popped, 20 accepted, count stays 4, drop_err stays 0. The FIFO drains with 20 last.
- Accumulator wrap: ACC_W=W=20, acc=0xFFFF0, push 0x00020 -> acc=0x00010, acc_ovf=1. Then assert clr_stats together with a push of 0x00005 -> acc=0x00005, acc_ovf=0.
- Backpressure stability: out_ready held 0 for 6 cycles while count=2 -> out_data and out_valid stay constant. The pointers wrap correctly across more than 3×DEPTH push/pop cycles of random sums, checked against a scoreboard queue.
